mm_slave_regfile: RTL and testbench
===================================

# mm_slave_regfile

Memory-mapped responder for the 8-bit bus_MM protocol. It accepts single-beat writes and reads from the bus master into a small register file. Reads return data one cycle after acceptance, marked by `readdatavalid`. Accepted writes and protocol errors are counted on two status outputs. The block sits at the slave end of bus_MM, opposite the existing write-only master.

## Interface
Parameters:
- `DEPTH`, 16: number of 8-bit registers, mapped at addresses 0..DEPTH-1; legal range 1..255.
- `ERR_DATA`, 8'hEE: value returned for an out-of-range read.

Ports:
- `CLK`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `address`  in  8  register address from the master.
- `write`  in  1  write request.
- `writedata`  in  8  write data.
- `read`  in  1  read request.
- `readdata`  out  8  read data, registered.
- `readdatavalid`  out  1  one-cycle pulse; `readdata` is valid while it is high.
- `waitrequest`  out  1  stall to the master; tied to 0 unless `MM_SLAVE_WAIT_EN` is defined.
- `wr_count`  out  8  number of accepted in-range writes; wraps 255 -> 0.
- `err_count`  out  8  number of protocol errors; saturates at 255.

## Operation
- State machine: `IDLE`, `ACCEPT`. `ACCEPT` is used only when `MM_SLAVE_WAIT_EN` is defined.
- An access is accepted on a rising edge where (`write` | `read`) = 1 and `waitrequest` = 0.
- Accepted write, address < DEPTH: `mem[address]` <= `writedata`; `wr_count` += 1.
- Accepted write, address >= DEPTH: memory is unchanged; `err_count` += 1; `wr_count` is unchanged.
- Accepted read, address < DEPTH: `readdata` <= `mem[address]`; `readdatavalid` <= 1.
- Accepted read, address >= DEPTH: `readdata` <= `ERR_DATA`; `readdatavalid` <= 1; `err_count` += 1.
- `write` and `read` both high: the write is performed and the read is dropped. `readdatavalid` stays 0 and `err_count` += 1.
  - If the write address is also out of range, `err_count` still increments by only 1.
- Idle bus (`write` = `read` = 0): no state change. Any address value is allowed, e.g. the master's idle value 99.
- `readdatavalid` is 0 in every cycle that does not follow an accepted read.
- Counter widths are 8 bits.
  - `wr_count` wraps modulo 256.
  - `err_count` holds at 8'hFF.

## Timing
- Reset, sampled at the edge: every `mem` entry = 0, `readdata` = 0, `readdatavalid` = 0, `wr_count` = 0, `err_count` = 0, FSM = `IDLE`.
- Reset asserted mid-access drops the pending access. No write occurs and no `readdatavalid` pulse is produced.
- Without the macro:
  - Write latency is 0. Memory updates at the accepting edge.
  - Read latency is 1. Data is accepted at edge N and `readdatavalid` is high from edge N to edge N+1.
  - Back-to-back accesses are allowed every cycle.
  - A read in the cycle after a write to the same address returns the new data.
- With the macro:
  - `IDLE` with a request: `waitrequest` = 1 combinationally, next state `ACCEPT`.
  - `ACCEPT`: `waitrequest` = 0, the access is performed at the end of the cycle, next state `IDLE`.
  - The master must hold `address`, `writedata`, `write` and `read` stable while `waitrequest` = 1.
  - Request dropped while in `ACCEPT`: return to `IDLE` with no access and no error.
  - Throughput is one access per 2 cycles. Read data appears 1 cycle after the `ACCEPT` edge.

## Configuration
- `MM_SLAVE_WAIT_EN`: when defined, the one-wait-state handshake above is compiled in.
- When undefined, `waitrequest` is constant 0, the FSM reduces to `IDLE` only, and the block is compatible with the existing master, which does not check `waitrequest`.

## Structure
- Package `mm_pkg` holds:
  - `MM_AW` = 8 and `MM_DW` = 8;
  - the default `ERR_DATA` constant;
  - typedef `mm_slv_state_t` {IDLE, ACCEPT}.
- One sub-module is natural: `mm_slave_mem`, a DEPTH x 8 register array with synchronous clear, one write port, and a registered read port.
- The top level contains the FSM, the address decode, and the counters.

## Test plan
- Reset, then write addr 3 data 8'h5A, then read addr 3 -> `readdata` = 8'h5A with `readdatavalid` for exactly 1 cycle; `wr_count` = 1.
- Pair with the existing write-only master for 40 cycles after reset:
  - addresses 0..15 hold data equal to their address;
  - `wr_count` = 16;
  - `err_count` = number of writes to addresses >= 16.
- Read addr 200 -> `readdata` = 8'hEE, `readdatavalid` = 1, `err_count` += 1. Write addr 200 -> no memory change, `err_count` += 1.
- `write` = `read` = 1 at addr 5 data 8'h11 -> `mem[5]` = 8'h11, no `readdatavalid`, `err_count` += 1. Then 300 error accesses -> `err_count` = 255 and stays there.
- Reset asserted the cycle after a read is accepted -> no stale data leaks out: `readdata` = 0 and `readdatavalid` = 0 on the next cycle, and all registers read back 0.
- With `MM_SLAVE_WAIT_EN` defined, a held write to addr 1:
  - `waitrequest` is 1 for one cycle, then 0;
  - the write lands one cycle later than without the macro;
  - back-to-back held accesses complete one every 2 cycles.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared bus_MM widths, default error data and slave FSM state type.
package mm_pkg;

    localparam int MM_AW = 8;
    localparam int MM_DW = 8;

    localparam logic [MM_DW-1:0] MM_ERR_DATA = 8'hEE;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCEPT = 1'b1
    } mm_slv_state_t;

    function automatic logic [MM_DW-1:0] sat_inc(input logic [MM_DW-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mm_slave_mem.sv
// DEPTH x 8 register array: synchronous clear, one write port, registered read port.
module mm_slave_mem
    import mm_pkg::*;
#(
    parameter int unsigned       DEPTH    = 16,
    parameter logic [MM_DW-1:0]  ERR_DATA = MM_ERR_DATA,
    localparam int unsigned      IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [MM_DW-1:0] wdata_i,
    input  logic             re_i,
    input  logic             rerr_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [MM_DW-1:0] rdata_o
);

    logic [MM_DW-1:0] mem_q [DEPTH];
    logic [MM_DW-1:0] rdata_q;

    // NOTE: the array is cleared in one cycle on reset, so it must be built from flops; a RAM macro cannot do this.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // NOTE: state updates use <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= rerr_i ? ERR_DATA : mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mm_slave_regfile.sv
// bus_MM slave register file: FSM, address decode, write/error counters.
// Define MM_SLAVE_WAIT_EN to add the one-wait-state waitrequest handshake.
module mm_slave_regfile
    import mm_pkg::*;
#(
    parameter int unsigned      DEPTH    = 16,
    parameter logic [MM_DW-1:0] ERR_DATA = MM_ERR_DATA
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [MM_AW-1:0] address,
    input  logic             write,
    input  logic [MM_DW-1:0] writedata,
    input  logic             read,
    output logic [MM_DW-1:0] readdata,
    output logic             readdatavalid,
    output logic             waitrequest,
    output logic [7:0]       wr_count,
    output logic [7:0]       err_count
);

    localparam int unsigned     IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [MM_AW:0]  DEPTH_C = DEPTH[MM_AW:0];

    mm_slv_state_t state_q, state_d;

    logic       req;
    logic       acc;
    logic       in_range;
    logic       mem_we;
    logic       rd_acc;
    logic       err_inc;
    logic       rdv_q;
    logic [7:0] wr_count_q, wr_count_d;
    logic [7:0] err_count_q, err_count_d;

    assign req      = write | read;
    assign in_range = ({1'b0, address} < DEPTH_C);

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
`ifdef MM_SLAVE_WAIT_EN
        case (state_q)
            IDLE:    if (req) state_d = ACCEPT;
            ACCEPT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
`else
        state_d = IDLE;
`endif
    end

    // NOTE: both outputs get a default first so no path through the case leaves them unassigned (no latch).
    always_comb begin
        waitrequest = 1'b0;
        acc         = 1'b0;
        case (state_q)
`ifdef MM_SLAVE_WAIT_EN
            IDLE:    waitrequest = req;
`else
            IDLE:    acc = req;
`endif
            ACCEPT:  acc = req;
            default: ;
        endcase
    end

    // A simultaneous write+read performs the write and drops the read.
    assign mem_we  = acc & write & in_range;
    assign rd_acc  = acc & read & ~write;
    assign err_inc = acc & ((write & read) | ~in_range);

    mm_slave_mem #(
        .DEPTH    (DEPTH),
        .ERR_DATA (ERR_DATA)
    ) u_mem (
        .clk_i   (CLK),
        .rst_i   (reset),
        .we_i    (mem_we),
        .waddr_i (address[IDX_W-1:0]),
        .wdata_i (writedata),
        .re_i    (rd_acc),
        .rerr_i  (~in_range),
        .raddr_i (address[IDX_W-1:0]),
        .rdata_o (readdata)
    );

    always_comb begin
        wr_count_d  = wr_count_q;
        err_count_d = err_count_q;
        if (mem_we) begin
            wr_count_d = wr_count_q + 8'd1;
        end
        if (err_inc) begin
            err_count_d = sat_inc(err_count_q);
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            rdv_q       <= 1'b0;
            wr_count_q  <= '0;
            err_count_q <= '0;
        end else begin
            rdv_q       <= rd_acc;
            wr_count_q  <= wr_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign readdatavalid = rdv_q;
    assign wr_count      = wr_count_q;
    assign err_count     = err_count_q;

endmodule

// File: tb/tb_mm_slave_regfile.sv
// Scoreboard bench for mm_slave_regfile; works with or without MM_SLAVE_WAIT_EN.
module tb_mm_slave_regfile;
    import mm_pkg::*;

    localparam int DEPTH = 16;
`ifdef MM_SLAVE_WAIT_EN
    localparam int EXP_WAIT = 1;
`else
    localparam int EXP_WAIT = 0;
`endif

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] address = 8'd99;
    logic [7:0] writedata = 8'd0;
    logic       write = 1'b0;
    logic       read = 1'b0;
    logic [7:0] readdata;
    logic       readdatavalid;
    logic       waitrequest;
    logic [7:0] wr_count;
    logic [7:0] err_count;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] mem_m [256];
    logic [7:0] exp_wr = 8'd0;
    logic [7:0] exp_err = 8'd0;
    logic [7:0] sb [$];
    logic [7:0] mon_exp;
    logic       mon_v;

    always #5 CLK = ~CLK;

    mm_slave_regfile #(
        .DEPTH    (DEPTH),
        .ERR_DATA (8'hEE)
    ) dut (
        .CLK           (CLK),
        .reset         (reset),
        .address       (address),
        .write         (write),
        .writedata     (writedata),
        .read          (read),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .waitrequest   (waitrequest),
        .wr_count      (wr_count),
        .err_count     (err_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Every negedge: readdatavalid must be high exactly when a read result is owed.
    always @(negedge CLK) begin
        mon_v = (sb.size() > 0);
        check("rdv", readdatavalid, mon_v);
        if (mon_v) begin
            mon_exp = sb.pop_front();
            check("rdata", readdata, mon_exp);
        end
    end

    function automatic void err_bump();
        if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
    endfunction

    function automatic void model_clear();
        foreach (mem_m[i]) mem_m[i] = 8'd0;
        exp_wr  = 8'd0;
        exp_err = 8'd0;
    endfunction

    function automatic void model_accept(input logic w, r, input logic [7:0] a, d);
        bit in_r = (a < DEPTH);
        if (w) begin
            if (in_r) begin
                mem_m[a] = d;
                exp_wr   = exp_wr + 8'd1;
            end
            if (r || !in_r) err_bump();
        end else if (r) begin
            sb.push_back(in_r ? mem_m[a] : 8'hEE);
            if (!in_r) err_bump();
        end
    endfunction

    // Called at a negedge; holds the request until accepted, returns at the following negedge.
    task automatic bus(input logic w, r, input logic [7:0] a, d);
        bit done = 0;
        bit acc_now;
        int waits = 0;
        write = w; read = r; address = a; writedata = d;
        for (int i = 0; i < 8 && !done; i++) begin
            #1;
            acc_now = !waitrequest;
            @(posedge CLK);
            if (acc_now) begin
                done = 1;
                model_accept(w, r, a, d);
            end else begin
                waits++;
            end
            @(negedge CLK);
        end
        write = 1'b0; read = 1'b0; address = 8'd99;
        check("accept", done, 1);
        check("wait_cycles", waits, EXP_WAIT);
    endtask

    task automatic idle(input int n);
        write = 1'b0; read = 1'b0; address = 8'd99;
        repeat (n) @(negedge CLK);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_wr_count"}, wr_count, exp_wr);
        check({tag, "_err_count"}, err_count, exp_err);
    endtask

    task automatic do_reset();
        reset = 1'b1; write = 1'b0; read = 1'b0; address = 8'd99;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        reset = 1'b0;
        model_clear();
        check("rst_readdata", readdata, 0);
        check_counts("rst");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   n;
        time  t0;
        model_clear();
        @(negedge CLK);
        do_reset();
        check("rst_waitrequest", waitrequest, 0);

        // Basic write then read, and read-after-write back to back.
        bus(1, 0, 8'd3, 8'h5A);
        bus(0, 1, 8'd3, 8'h00);
        check("basic_wr_count", wr_count, 8'd1);
        bus(1, 0, 8'd7, 8'hC3);
        bus(0, 1, 8'd7, 8'h00);
        idle(2);

        // Write-only master pairing: addresses 0..19 with data = address, then idle at 99.
        do_reset();
        for (int i = 0; i < 20; i++) bus(1, 0, 8'(i), 8'(i));
        idle(20);
        check("master_wr_count", wr_count, 8'd16);
        check("master_err_count", err_count, 8'd4);
        for (int i = 0; i < DEPTH; i++) bus(0, 1, 8'(i), 8'h00);
        idle(2);

        // Out-of-range read and write.
        bus(0, 1, 8'd200, 8'h00);
        check("oor_rd_err", err_count, 8'd5);
        bus(1, 0, 8'd200, 8'h77);
        check("oor_wr_err", err_count, 8'd6);
        bus(0, 1, 8'd8, 8'h00);
        check_counts("oor");

        // Simultaneous write and read.
        bus(1, 1, 8'd5, 8'h11);
        idle(1);
        bus(0, 1, 8'd5, 8'h00);
        bus(1, 1, 8'd200, 8'h22);
        check_counts("both");
        check("both_err_count", err_count, 8'd8);

        // Back-to-back throughput.
        t0 = $time;
        for (int i = 0; i < 4; i++) bus(1, 0, 8'(10 + i), 8'(8'hA0 + i));
        check("b2b_cycles", int'(($time - t0) / 10), 4 * (1 + EXP_WAIT));
        for (int i = 0; i < 4; i++) bus(0, 1, 8'(10 + i), 8'h00);

        // Error counter saturation.
        for (int i = 0; i < 300; i++) begin
            if (i % 3 == 0) bus(0, 1, 8'd250, 8'h00);
            else            bus(1, 0, 8'd250, 8'(i));
        end
        check("sat_err_count", err_count, 8'hFF);
        bus(1, 1, 8'd200, 8'h00);
        check("sat_hold", err_count, 8'hFF);
        check_counts("sat");

        // Write counter wrap.
        n = 256 - int'(exp_wr);
        for (int i = 0; i < n; i++) bus(1, 0, 8'd0, 8'(i));
        check("wrap_wr_count", wr_count, 8'd0);
        bus(1, 0, 8'd1, 8'h3C);
        check("wrap_plus_one", wr_count, 8'd1);
        bus(0, 1, 8'd0, 8'h00);
        bus(0, 1, 8'd1, 8'h00);
        idle(1);

`ifdef MM_SLAVE_WAIT_EN
        // Request dropped while in ACCEPT: no access, no error.
        write = 1'b1; address = 8'd1; writedata = 8'hAB;
        #1 check("drop_wait_hi", waitrequest, 1);
        @(posedge CLK);
        @(negedge CLK);
        write = 1'b0; address = 8'd99;
        #1 check("drop_wait_lo", waitrequest, 0);
        @(posedge CLK);
        @(negedge CLK);
        check_counts("drop");
        bus(0, 1, 8'd1, 8'h00);
`endif

        // Reset the cycle after an accepted read: nothing stale leaks out.
        bus(0, 1, 8'd5, 8'h00);
        reset = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        reset = 1'b0;
        model_clear();
        check("rst_after_rd_data", readdata, 0);
        check("rst_after_rd_rdv", readdatavalid, 0);
        for (int i = 0; i < DEPTH; i++) bus(0, 1, 8'(i), 8'h00);

        // Reset coincident with a request drops it.
        reset = 1'b1; write = 1'b1; address = 8'd2; writedata = 8'h33;
        @(posedge CLK);
        @(negedge CLK);
        write = 1'b0; read = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        reset = 1'b0; read = 1'b0; address = 8'd99;
        idle(1);
        bus(0, 1, 8'd2, 8'h00);
        check_counts("rst_drop");

        idle(3);
        check("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
